// File: rtl/if2_inst_queue_if.sv
// IF2 -> ID instruction queue bus: fetch pair in, decode pair out,
// decode consume request, branch flush and front-end stall.
interface if2_inst_queue_if;
    logic [31:0] i_PC1;
    logic [31:0] i_PC2;
    logic [31:0] i_inst1;
    logic [31:0] i_inst2;
    logic [1:0]  i_is_valid;
    logic [1:0]  i_pop;
    logic        flush_BR;
    logic [31:0] o_PC1;
    logic [31:0] o_inst1;
    logic [31:0] o_PC2;
    logic [31:0] o_inst2;
    logic [1:0]  o_is_valid;
    logic        o_stall_IQ;

    // front end / decode side
    modport master (
        output i_PC1, i_PC2, i_inst1, i_inst2, i_is_valid, i_pop, flush_BR,
        input  o_PC1, o_inst1, o_PC2, o_inst2, o_is_valid, o_stall_IQ
    );

    // queue side
    modport slave (
        input  i_PC1, i_PC2, i_inst1, i_inst2, i_is_valid, i_pop, flush_BR,
        output o_PC1, o_inst1, o_PC2, o_inst2, o_is_valid, o_stall_IQ
    );
endinterface

// File: rtl/if2_inst_queue.sv
// Dual-issue instruction fetch queue: circular FIFO of {PC, inst} that
// accepts up to two fetched slots per cycle and presents the two oldest
// entries to decode. Stalls the front end whenever a full pair might not fit.
module if2_inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    if2_inst_queue_if.slave  q
);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - 2);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic             stall;
    logic             push_ok;
    logic [1:0]       n_push;
    logic [1:0]       n_pop;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [31:0]      wr0_pc, wr0_inst;

    assign stall   = (count_q > STALL_LVL);
    assign push_ok = !stall && !q.flush_BR;
    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Pack valid slots toward tail; a lone younger slot still lands at tail.
    assign wr0_pc   = q.i_is_valid[0] ? q.i_PC1   : q.i_PC2;
    assign wr0_inst = q.i_is_valid[0] ? q.i_inst1 : q.i_inst2;

    // Accepted push count and clipped pop count (i_pop=10 is ignored).
    always_comb begin
        n_push = 2'd0;
        n_pop  = 2'd0;
        if (push_ok)
            n_push = {1'b0, q.i_is_valid[0]} + {1'b0, q.i_is_valid[1]};
        if (q.i_pop == 2'b11) begin
            if (count_q >= CNT_W'(2))
                n_pop = 2'd2;
            else if (count_q >= CNT_W'(1))
                n_pop = 2'd1;
        end else if (q.i_pop == 2'b01) begin
            if (count_q >= CNT_W'(1))
                n_pop = 2'd1;
        end
    end

    // Entry storage; intentionally not reset, qualified by count instead.
    always_ff @(posedge clk) begin
        if (push_ok && (q.i_is_valid != 2'b00)) begin
            pc_q[tail_q]   <= wr0_pc;
            inst_q[tail_q] <= wr0_inst;
        end
        if (push_ok && (q.i_is_valid == 2'b11)) begin
            pc_q[tail_p1]   <= q.i_PC2;
            inst_q[tail_p1] <= q.i_inst2;
        end
    end

    // Pointer and occupancy update; flush discards same-cycle push and pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (q.flush_BR) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(n_pop);
            tail_q  <= tail_q + PTR_W'(n_push);
            count_q <= count_q + CNT_W'(n_push) - CNT_W'(n_pop);
        end
    end

    assign q.o_PC1      = pc_q[head_q];
    assign q.o_inst1    = inst_q[head_q];
    assign q.o_PC2      = pc_q[head_p1];
    assign q.o_inst2    = inst_q[head_p1];
    assign q.o_is_valid = {count_q >= CNT_W'(2), count_q >= CNT_W'(1)};
    assign q.o_stall_IQ = stall;
endmodule

// File: tb/tb_if2_inst_queue.sv
// Bench for if2_inst_queue: directed scenarios followed by random traffic,
// all checked against a queue-based program-order model.
module tb_if2_inst_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [63:0] mq [$];
    logic [31:0] pc_seq;

    always #5 clk = ~clk;

    if2_inst_queue_if bus ();

    if2_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .q    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("is_valid", {30'd0, bus.o_is_valid}, {30'd0, (sz >= 2), (sz >= 1)});
        chk("stall", {31'd0, bus.o_stall_IQ}, {31'd0, (sz > DEPTH - 2)});
        if (sz >= 1) begin
            chk("pc1", bus.o_PC1, mq[0][63:32]);
            chk("inst1", bus.o_inst1, mq[0][31:0]);
        end
        if (sz >= 2) begin
            chk("pc2", bus.o_PC2, mq[1][63:32]);
            chk("inst2", bus.o_inst2, mq[1][31:0]);
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), update
    // the model from the queue rules, then check after the next rising edge.
    task automatic step(input logic [1:0] v, input logic [1:0] p, input logic f,
                        input logic [31:0] pc1, input logic [31:0] pc2,
                        input logic [31:0] in1, input logic [31:0] in2);
        int  sz;
        int  np;
        bit  st;
        bus.i_is_valid = v;
        bus.i_pop      = p;
        bus.flush_BR   = f;
        bus.i_PC1      = pc1;
        bus.i_PC2      = pc2;
        bus.i_inst1    = in1;
        bus.i_inst2    = in2;
        sz = mq.size();
        st = (sz > DEPTH - 2);
        np = 0;
        if (f) begin
            mq.delete();
        end else begin
            if (p == 2'b11)      np = (sz >= 2) ? 2 : sz;
            else if (p == 2'b01) np = (sz >= 1) ? 1 : 0;
            repeat (np) void'(mq.pop_front());
            if (!st) begin
                if (v[0]) mq.push_back({pc1, in1});
                if (v[1]) mq.push_back({pc2, in2});
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic push_pair(input logic [1:0] v, input logic [1:0] p);
        step(v, p, 1'b0, pc_seq, pc_seq + 32'd4, ~pc_seq, ~(pc_seq + 32'd4));
        pc_seq = pc_seq + 32'd8;
    endtask

    task automatic idle(input logic [1:0] p, input logic f);
        step(2'b00, p, f, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        bus.i_is_valid = 2'b00;
        bus.i_pop      = 2'b00;
        bus.flush_BR   = 1'b0;
        bus.i_PC1      = '0;
        bus.i_PC2      = '0;
        bus.i_inst1    = '0;
        bus.i_inst2    = '0;
        pc_seq         = 32'h1c00_0100;

        // reset state
        #12;
        chk("rst_valid", {30'd0, bus.o_is_valid}, 32'd0);
        chk("rst_stall", {31'd0, bus.o_stall_IQ}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2'b00, 1'b0);

        // pair push, visible next cycle
        step(2'b11, 2'b00, 1'b0, 32'h1c00_0000, 32'h1c00_0004, 32'h0000_0013, 32'h0010_0093);
        chk("pair_valid", {30'd0, bus.o_is_valid}, 32'd3);
        chk("pair_pc1", bus.o_PC1, 32'h1c00_0000);
        chk("pair_pc2", bus.o_PC2, 32'h1c00_0004);
        idle(2'b11, 1'b0);

        // younger-only then older-only push pack in order
        step(2'b10, 2'b00, 1'b0, 32'hdead_0000, 32'h1c00_0014, 32'h1111_1111, 32'h2222_2222);
        step(2'b01, 2'b00, 1'b0, 32'h1c00_0018, 32'hdead_0004, 32'h3333_3333, 32'h4444_4444);
        chk("pack_pc1", bus.o_PC1, 32'h1c00_0014);
        chk("pack_pc2", bus.o_PC2, 32'h1c00_0018);
        chk("pack_inst1", bus.o_inst1, 32'h2222_2222);
        idle(2'b00, 1'b1);

        // fill to full, stall, refused push with pop
        repeat (3) push_pair(2'b11, 2'b00);
        chk("six_nostall", {31'd0, bus.o_stall_IQ}, 32'd0);
        push_pair(2'b11, 2'b00);
        chk("full_stall", {31'd0, bus.o_stall_IQ}, 32'd1);
        push_pair(2'b11, 2'b11);
        chk("refused_stall", {31'd0, bus.o_stall_IQ}, 32'd0);
        push_pair(2'b01, 2'b00);
        chk("seven_stall", {31'd0, bus.o_stall_IQ}, 32'd1);
        push_pair(2'b01, 2'b01);
        chk("seven_refused", {31'd0, bus.o_stall_IQ}, 32'd0);
        idle(2'b00, 1'b1);

        // steady push/pop across pointer wrap
        push_pair(2'b11, 2'b00);
        repeat (10) push_pair(2'b11, 2'b11);
        idle(2'b00, 1'b1);

        // pop clipping at count=1
        push_pair(2'b01, 2'b00);
        idle(2'b11, 1'b0);
        chk("clip_valid", {30'd0, bus.o_is_valid}, 32'd0);
        idle(2'b11, 1'b0);
        idle(2'b10, 1'b0);

        // flush at count=5 discards simultaneous push and pop
        push_pair(2'b11, 2'b00);
        push_pair(2'b11, 2'b00);
        push_pair(2'b01, 2'b00);
        step(2'b11, 2'b01, 1'b1, 32'hbad0_0000, 32'hbad0_0004, 32'h0, 32'h0);
        chk("flush_valid", {30'd0, bus.o_is_valid}, 32'd0);
        step(2'b01, 2'b00, 1'b0, 32'h1c00_2000, 32'h0, 32'h5555_5555, 32'h0);
        chk("post_flush_pc1", bus.o_PC1, 32'h1c00_2000);

        // asynchronous reset mid-operation
        push_pair(2'b11, 2'b00);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", {30'd0, bus.o_is_valid}, 32'd0);
        chk("async_rst_stall", {31'd0, bus.o_stall_IQ}, 32'd0);
        mq.delete();
        @(negedge clk);
        rstn = 1'b1;
        idle(2'b00, 1'b0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic [1:0] v;
            logic [1:0] p;
            logic       f;
            v = 2'($urandom_range(0, 3));
            p = 2'($urandom_range(0, 3));
            f = ($urandom_range(0, 39) == 0);
            step(v, p, f, $urandom, $urandom, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/if2_inst_queue.md
# if2_inst_queue

Instruction fetch queue between IF2 and ID in the dual-issue front end. It accepts up to two fetched instructions per cycle, each with its PC, from the IF2 side. It buffers them in program order in a circular FIFO and presents the two oldest entries to decode. It raises a stall toward the front end when it cannot guarantee room for a full fetch pair, and it empties on branch flush.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥4
- PTR_W, $clog2(DEPTH), pointer width (derived)

Ports (reset is asynchronous, active-low; one clock):
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- i_PC1  input  32  PC of older fetched slot
- i_PC2  input  32  PC of younger fetched slot
- i_inst1  input  32  instruction of older slot
- i_inst2  input  32  instruction of younger slot
- i_is_valid  input  2  slot valid mask; bit0 = older slot, bit1 = younger slot; any of 00/01/10/11
- i_pop  input  2  decode consume request; 00, 01 or 11 (10 treated as 00)
- flush_BR  input  1  branch mispredict flush
- o_PC1, o_inst1  output  32 each  head entry (oldest)
- o_PC2, o_inst2  output  32 each  head+1 entry
- o_is_valid  output  2  bit0 = head valid, bit1 = head+1 valid
- o_stall_IQ  output  1  queue cannot accept a pair; front end must hold

## Operation
- State: storage arrays pc_q/inst_q[DEPTH] (not reset), head and tail pointers (PTR_W bits, wrap mod DEPTH), count (PTR_W+1 bits, 0..DEPTH).
- o_stall_IQ = (count > DEPTH-2), combinational from the registered count only.
- Push is accepted when o_stall_IQ=0 and flush_BR=0. It is ignored entirely when o_stall_IQ=1, and the upstream stage holds its data.
- Push packing: valid slots are written in order starting at tail; slot1 before slot2. n_push = popcount(i_is_valid) when accepted, else 0.
  - 01: slot1 goes to tail.
  - 10: slot2 goes to tail.
  - 11: slot1 goes to tail, slot2 goes to tail+1.
- Pop: n_pop = 2 for i_pop=11 with count≥2; n_pop = 1 for i_pop=01 (or 11 with count=1) with count≥1; otherwise 0. Requests beyond available entries are clipped, never underflow.
- Update: tail += n_push, head += n_pop, count += n_push − n_pop. Both pointers wrap modulo DEPTH.
- Push and pop in the same cycle are both performed. Stall is judged on pre-pop count, so a same-cycle pop never admits a push at count > DEPTH-2.
- Flush: head, tail and count go to 0 next edge. Same-cycle push and pop are discarded.
- Outputs are combinational reads: o_*1 = entry[head], o_*2 = entry[head+1 mod DEPTH]. o_is_valid = {count≥2, count≥1}.
- o_PC/o_inst are don't-care when the corresponding o_is_valid bit is 0.

## Timing
- Reset: head=tail=count=0 → o_is_valid=00, o_stall_IQ=0. Storage is unreset.
- Latency: an entry pushed at edge N is visible on the outputs after edge N, i.e. in cycle N+1. There is no bypass from input to output in the same cycle.
- Popped entries leave the outputs after the edge where pop occurs. The next entries shift into o_*1/o_*2 in the same cycle that follows.
- o_stall_IQ changes only after clock edges, or asynchronously to 0 on reset.
- Reset mid-operation: all buffered entries are lost immediately, and outputs become invalid without waiting for a clock.
- Full boundary: with count = DEPTH-1 or DEPTH, the queue stalls even for a single-slot push. count never exceeds DEPTH.

## Test plan
- Reset, then idle → o_is_valid=00, o_stall_IQ=0. Push 11 (PC 0x1c000000/0x1c000004), no pop → next cycle o_is_valid=11, o_PC1=0x1c000000, o_PC2=0x1c000004.
- Push 10 (PC2=0x1c000014) into an empty queue, then push 01 (PC1=0x1c000018) → o_PC1=0x1c000014, o_PC2=0x1c000018, count=2.
- Push 11 every cycle, no pop, DEPTH=8 → o_stall_IQ=1 after 4th push (count=8). A 5th push with i_pop=11 is refused and count becomes 6. o_stall_IQ stays 0 next cycle once count=6.
- Wrap-around: push 11 and pop 11 for 10 cycles with sequential PCs → outputs stay in strict PC order across the pointer wrap, and count stays constant.
- Pop clipping: count=1, i_pop=11 → count=0, o_is_valid=00, no underflow.
- Flush with count=5 and a simultaneous push 11/pop 01 → next cycle count=0, o_is_valid=00. The pushed pair is absent, and the following push appears at o_*1.
